// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: load-use stalls,
// redirect flushes, data-memory wait freezing, EX forwarding selects and debug counters.
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_wR,
  input  logic             ex_rf_we,
  input  logic [1:0]       ex_wd_sel,
  input  logic             ex_have_inst,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_wR,
  input  logic             mem_rf_we,
  input  logic [1:0]       mem_wd_sel,
  input  logic             mem_dram_we,
  input  logic             mem_have_inst,
  input  logic [4:0]       wb_wR,
  input  logic             wb_rf_we,
  input  logic             dram_ack,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             dram_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             fsm_state
);

  localparam int WC_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MAX_WAIT - 1);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;

  logic mem_access;
  logic timeout;
  logic freeze;
  logic redirect;
  logic load_hit;
  logic load_use;
  logic mem_fwd_ok;
  logic wb_fwd_ok;

  // rst_n is active-high; every combinational output takes its reset value while it is asserted.
  assign mem_access = mem_have_inst & (mem_dram_we | (mem_wd_sel == 2'b01));
  assign dram_req   = ~rst_n & mem_access;
  assign timeout    = (state == MEM_WAIT) & ~dram_ack & (wait_cnt == WAIT_LAST);
  assign freeze     = dram_req & ~dram_ack & ~timeout;
  assign redirect   = ~rst_n & ~freeze & ex_redirect & ex_have_inst;

  assign load_hit = ex_have_inst & ex_rf_we & (ex_wd_sel == 2'b01) & (ex_wR != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_wR)) | (id_use_rs2 & (id_rs2 == ex_wR)));
  assign load_use = ~rst_n & ~freeze & ~redirect & load_hit;

  assign pc_stall    = freeze | load_use;
  assign ifid_stall  = freeze | load_use;
  assign idex_stall  = freeze;
  assign exmem_stall = freeze;
  assign ifid_flush  = rst_n | redirect;
  assign idex_flush  = rst_n | redirect | load_use;
  assign memwb_flush = rst_n | freeze;

  // A load in MEM has no data yet, so only non-load MEM results are forwarded.
  assign mem_fwd_ok = mem_have_inst & mem_rf_we & (mem_wd_sel != 2'b01) & (mem_wR != 5'd0);
  assign wb_fwd_ok  = wb_rf_we & (wb_wR != 5'd0);

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst_n) begin
      if (mem_fwd_ok && mem_wR == ex_rs1)     fwd_a = 2'b01;
      else if (wb_fwd_ok && wb_wR == ex_rs1)  fwd_a = 2'b10;
      if (mem_fwd_ok && mem_wR == ex_rs2)     fwd_b = 2'b01;
      else if (wb_fwd_ok && wb_wR == ex_rs2)  fwd_b = 2'b10;
    end
  end

  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (dram_req && !dram_ack) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (dram_ack) begin
            state <= RUN;
          end else if (timeout) begin
            state   <= RUN;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
      if (pc_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (redirect && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
